// File: rtl/nested_struct_pipe.sv
// nested_struct_pipe
//   Registered, flow-controlled nested-struct field processor. A packet
//   {base{addr,data,valid},id,cmd,ready} is accepted over valid/ready,
//   transformed field by field (or passed through unchanged when in_bypass=1),
//   and buffered in a 2-entry in-order output FIFO. Outputs come only from
//   registers, so there is no combinational path from input to output.
//   Optional feature: define NSP_STATS_EN to add the stat_count port, a
//   saturating count of output transfers.
module nested_struct_pipe #(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        ID_W     = 16,
    parameter int unsigned        CMD_W    = 4,
    parameter int unsigned        ADDR_INC = 1,
    parameter logic [DATA_W-1:0]  DATA_XOR = 32'hDEADBEEF,
    parameter int unsigned        ID_INC   = 100,
    parameter logic [CMD_W-1:0]   CMD_OR   = 4'b1010,
    localparam int unsigned       PKT_W    = ADDR_W + DATA_W + ID_W + CMD_W + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] in_data,
    input  logic             in_bypass,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef NSP_STATS_EN
    ,
    output logic [15:0]      stat_count
`endif
);

    // Packet layout, MSB first: addr | data | valid | id | cmd | ready
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              valid;
    } base_t;

    typedef struct packed {
        base_t             base;
        logic [ID_W-1:0]   id;
        logic [CMD_W-1:0]  cmd;
        logic              ready;
    } pkt_t;

    pkt_t             w_in;
    pkt_t             w_xf;
    logic [PKT_W-1:0] w_next;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    logic [PKT_W-1:0] r_head;
    logic [PKT_W-1:0] r_tail;
    logic [1:0]       r_count;
    logic             r_out_valid;
    logic             r_in_ready;

    assign w_in   = in_data;
    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Per-field transform; every field is read from the incoming packet, so
    // ready' takes the original base.valid rather than the modified one.
    always_comb begin
        // NOTE: assign a default first so every path writes every field and no latch is inferred.
        w_xf            = w_in;
        w_xf.base.addr  = w_in.base.addr + ADDR_W'(ADDR_INC);
        w_xf.base.data  = w_in.base.data ^ DATA_XOR;
        w_xf.base.valid = w_in.base.valid & w_in.ready;
        w_xf.id         = w_in.id + ID_W'(ID_INC);
        w_xf.cmd        = w_in.cmd | CMD_OR;
        w_xf.ready      = w_in.base.valid;
    end

    assign w_next = in_bypass ? in_data : w_xf;

    // Next occupancy: push and pop on the same edge leave the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage and registered handshake flags.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: both storage entries are reset because out_data must read zero after reset;
            // the tail is cleared too so the FIFO never exposes stale content.
            r_count     <= 2'd0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_head      <= '0;
            r_tail      <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != 2'd0);
            r_in_ready  <= (w_count_nxt != 2'd2);

            // The new packet lands in the head when the head is empty or being
            // vacated by a pop with nothing behind it; otherwise it queues in the tail.
            if (w_push) begin
                if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) begin
                    r_head <= w_next;
                end else begin
                    r_tail <= w_next;
                end
            end

            // Full FIFO popping: the tail advances into the head.
            if (w_pop && (r_count == 2'd2)) begin
                r_head <= r_tail;
            end
        end
    end

    assign out_data  = r_head;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

`ifdef NSP_STATS_EN
    logic [15:0] r_stat_count;

    // Saturating count of output transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_count <= 16'd0;
        end else if (w_pop && (r_stat_count != 16'hFFFF)) begin
            r_stat_count <= r_stat_count + 16'd1;
        end
    end

    assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_nested_struct_pipe.sv
// tb_nested_struct_pipe
//   Scoreboard bench for nested_struct_pipe. The driver pushes the expected
//   output packet whenever an input transfer happens; an independent monitor
//   pops and compares on every output transfer. The reference model computes
//   fields with plain modular arithmetic on bit ranges.
module tb_nested_struct_pipe;

    localparam int PKT_W = 62;

    logic             clk = 1'b0;
    logic             rst;
    logic [PKT_W-1:0] in_data;
    logic             in_bypass;
    logic             in_valid;
    logic             in_ready;
    logic [PKT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef NSP_STATS_EN
    logic [15:0]      stat_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    logic [PKT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    nested_struct_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef NSP_STATS_EN
        ,
        .stat_count(stat_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: fields by bit position, adds done in integer arithmetic mod 2^width.
    function automatic logic [PKT_W-1:0] model(input logic [PKT_W-1:0] p, input logic byp);
        int unsigned addr, id;
        logic [31:0] data;
        logic        v, r;
        logic [3:0]  cmd;
        if (byp) return p;
        addr = (int'(p[61:54]) + 1) % 256;
        data = p[53:22] ^ 32'hDEADBEEF;
        v    = p[21];
        id   = (int'(p[20:5]) + 100) % 65536;
        cmd  = p[4:1] | 4'b1010;
        r    = p[0];
        return {addr[7:0], data, v & r, id[15:0], cmd, v};
    endfunction

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input logic v, input logic byp, input logic [PKT_W-1:0] d, output logic acc);
        in_valid  = v;
        in_bypass = byp;
        in_data   = d;
        @(negedge clk);
        acc = v && in_ready && !rst;
        if (acc) exp_q.push_back(model(d, byp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, acc);
    endtask

    // Monitor: compare every output transfer and check head stability under backpressure.
    logic             hold_prev = 1'b0;
    logic [PKT_W-1:0] data_prev = '0;
    always @(negedge clk) begin
        if (!rst && hold_prev) check("out_data_stable", out_data, data_prev);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_data, '0);
                if (out_data == '0) begin
                    n_errors++;
                    $display("FAIL unexpected_output: got %h expected no transfer", out_data);
                end
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
            n_out++;
        end
        hold_prev = !rst && out_valid && !out_ready;
        data_prev = out_data;
    end

    localparam logic [PKT_W-1:0] P2 = {8'hFF, 32'h0000_0000, 1'b1, 16'hFFF0, 4'h5, 1'b1};
    localparam logic [PKT_W-1:0] E2 = {8'h00, 32'hDEADBEEF, 1'b1, 16'h0054, 4'hF, 1'b1};

    initial begin
        logic             acc;
        logic [PKT_W-1:0] pkt, head_a;
        int               base_out;
        logic             ready_ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_data", out_data, 0);
`ifdef NSP_STATS_EN
        check("reset_stat_count", stat_count, 0);
`endif
        rst = 1'b0;

        // Transform with wrap in addr and id
        out_ready = 1'b1;
        drive(1'b1, 1'b0, P2, acc);
        check("t2_accepted", acc, 1);
        check("t2_out_valid", out_valid, 1);
        check("t2_out_data", out_data, E2);
        idle(1);

        // Bypass passes the packet unchanged
        drive(1'b1, 1'b1, P2, acc);
        check("bypass_out_data", out_data, P2);
        idle(1);

        // valid'/ready' logic
        drive(1'b1, 1'b0, {8'h12, 32'h1234_5678, 1'b1, 16'h0001, 4'h0, 1'b0}, acc);
        check("v1r0_valid", out_data[21], 0);
        check("v1r0_ready", out_data[0], 1);
        drive(1'b1, 1'b0, {8'h34, 32'h0, 1'b0, 16'h0002, 4'h1, 1'b1}, acc);
        check("v0r1_valid", out_data[21], 0);
        check("v0r1_ready", out_data[0], 0);
        idle(2);

        // Mid-stream reset discards buffered packets
        out_ready = 1'b0;
        drive(1'b1, 1'b0, {$urandom, $urandom}, acc);
        drive(1'b1, 1'b0, {$urandom, $urandom}, acc);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_data", out_data, 0);
`ifdef NSP_STATS_EN
        check("midreset_stat_count", stat_count, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Backpressure: two fill the FIFO, the third waits upstream
        out_ready = 1'b0;
        base_out  = n_out;
        drive(1'b1, 1'b0, {$urandom, $urandom}, acc);
        check("bp_acc_a", acc, 1);
        head_a = out_data;
        drive(1'b1, 1'b0, {$urandom, $urandom}, acc);
        check("bp_acc_b", acc, 1);
        check("bp_in_ready_full", in_ready, 0);
        pkt = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, pkt, acc);
            check("bp_c_held", acc, 0);
        end
        check("bp_head_stable", out_data, head_a);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) drive(1'b1, 1'b0, pkt, acc);
        check("bp_c_accepted", acc, 1);
        idle(4);
        check("bp_out_count", n_out - base_out, 3);
        check("bp_queue_empty", exp_q.size(), 0);

        // Streaming: 100 back-to-back transfers
        begin
`ifdef NSP_STATS_EN
            logic [15:0] stat0;
            stat0 = stat_count;
`endif
            base_out = n_out;
            ready_ok = 1'b1;
            for (int i = 0; i < 100; i++) begin
                if (!in_ready) ready_ok = 1'b0;
                drive(1'b1, $urandom_range(0, 3) == 0, {$urandom, $urandom}, acc);
            end
            idle(1);
            check("stream_in_ready_held", ready_ok, 1);
            check("stream_transfers", n_out - base_out, 100);
`ifdef NSP_STATS_EN
            check("stream_stat_count", stat_count - stat0, 100);
`endif
        end

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, {$urandom, $urandom}, acc);
        end
        out_ready = 1'b1;
        idle(4);
        check("random_queue_empty", exp_q.size(), 0);
        check("random_out_valid_idle", out_valid, 0);

`ifdef NSP_STATS_EN
        // Saturation at FFFF
        for (int i = 0; i < 65600; i++) drive(1'b1, 1'b0, {$urandom, $urandom}, acc);
        idle(2);
        check("stat_saturated", stat_count, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
